// File: rtl/image_stream_out.sv
// Streams a full image BRAM into a downstream FIFO. A 2-entry skid buffer
// absorbs the one-cycle BRAM read latency, so out_full can stall output without dropping pixels.
module image_stream_out #(
    parameter  int WIDTH      = 1280,
    parameter  int HEIGHT     = 720,
    localparam int IMAGE_SIZE = WIDTH * HEIGHT,
    localparam int ADDR_BITS  = $clog2(IMAGE_SIZE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] image_bram_rd_addr,
    input  logic [23:0]          image_bram_rd_data,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [23:0]          out_dout,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_BITS = $clog2(IMAGE_SIZE + 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR    = ADDR_BITS'(IMAGE_SIZE - 1);
    localparam logic [CNT_BITS-1:0]  FRAME_PIXELS = CNT_BITS'(IMAGE_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_pending;
    logic [23:0]          skid_mem [2];
    logic                 skid_wr_ptr;
    logic                 skid_rd_ptr;
    logic [1:0]           skid_count;
    logic [CNT_BITS-1:0]  wr_cnt;

    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 last_issue;
    logic                 frame_written;
    logic                 start_accept;
    logic [1:0]           occupancy;
    logic [1:0]           occupancy_after_pop;
    logic [1:0]           skid_count_next;
    logic [CNT_BITS-1:0]  wr_cnt_next;

    // Read issue rule: entries held plus the read in flight, less this
    // cycle's pop, must leave room so the skid buffer can never overflow.
    always_comb begin
        push                = rd_pending;
        pop                 = (skid_count != 2'd0) && !out_full;
        occupancy           = skid_count + 2'(rd_pending);
        occupancy_after_pop = occupancy - 2'(pop);
        issue               = (state == STREAM) && (occupancy_after_pop < 2'd2);
        last_issue          = issue && (rd_addr == LAST_ADDR);
        skid_count_next     = skid_count + 2'(push) - 2'(pop);
        wr_cnt_next         = wr_cnt + CNT_BITS'(pop);
        frame_written       = (wr_cnt_next == FRAME_PIXELS) && (skid_count_next == 2'd0);
    end

    assign out_wr_en          = pop;
    assign out_dout           = skid_mem[skid_rd_ptr];
    assign image_bram_rd_addr = rd_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next   = state;
        start_accept = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (frame_written) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr     <= '0;
            rd_pending  <= 1'b0;
            skid_wr_ptr <= 1'b0;
            skid_rd_ptr <= 1'b0;
            skid_count  <= 2'd0;
            wr_cnt      <= '0;
            // NOTE: the two skid entries are reset because out_dout is read
            // straight from the head entry and must come out of reset as zero.
            for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
        end else begin
            rd_pending <= issue;

            // Address saturates on the last pixel; a new frame restarts it at 0.
            if (start_accept) begin
                rd_addr <= '0;
            end else if (issue && (rd_addr != LAST_ADDR)) begin
                rd_addr <= rd_addr + 1'b1;
            end

            if (start_accept) begin
                wr_cnt <= '0;
            end else begin
                wr_cnt <= wr_cnt_next;
            end

            if (push) begin
                skid_mem[skid_wr_ptr] <= image_bram_rd_data;
                skid_wr_ptr           <= ~skid_wr_ptr;
            end
            if (pop) begin
                skid_rd_ptr <= ~skid_rd_ptr;
            end
            skid_count <= skid_count_next;
        end
    end

endmodule

// File: doc/image_stream_out.md
IMAGE_STREAM_OUT -- requirements
Module: image_stream_out

Interface
- REQ-001: Parameter WIDTH, default 1280, image width in pixels.
- REQ-002: Parameter HEIGHT, default 720, image height in pixels.
- REQ-003: Derived IMAGE_SIZE = WIDTH*HEIGHT; ADDR_BITS = $clog2(IMAGE_SIZE).
- REQ-004: clock  input  1  sole clock; all state updates on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: start  input  1  one-cycle request to stream the full image BRAM.
- REQ-007: image_bram_rd_addr  output  ADDR_BITS  read address to the image BRAM.
- REQ-008: image_bram_rd_data  input  24  BRAM read data, valid exactly 1 cycle after address.
- REQ-009: out_full  input  1  downstream FIFO full; no write permitted while high.
- REQ-010: out_wr_en  output  1  write strobe to downstream FIFO.
- REQ-011: out_dout  output  24  pixel word, BRAM word passed unmodified, byte order preserved.
- REQ-012: busy  output  1  high from accepted start until done pulse inclusive.
- REQ-013: done  output  1  one-cycle pulse after last pixel written.

Function
- REQ-014: FSM states IDLE, STREAM, DRAIN, DONE.
- REQ-015: IDLE -> STREAM when start=1; start ignored in every other state.
- REQ-016: STREAM issues reads at addresses 0..IMAGE_SIZE-1 in increasing order, each exactly once.
- REQ-017: Returned data enters a 2-entry skid FIFO; a read is issued in a cycle only if skid occupancy plus reads in flight (max 1) < 2 after this cycle's pop.
- REQ-018: out_wr_en = skid non-empty AND NOT out_full; out_dout = skid head; pop on out_wr_en.
- REQ-019: out_wr_en never asserted while out_full=1; no pixel dropped or duplicated under any out_full pattern.
- REQ-020: With out_full held 0, throughput 1 pixel/cycle; start sampled at edge E0 -> address 0 presented in cycle after E0 -> first out_wr_en 3 cycles after E0.
- REQ-021: STREAM -> DRAIN after read IMAGE_SIZE-1 issued; DRAIN -> DONE when last pixel written and skid empty.
- REQ-022: DONE asserts done for exactly 1 cycle, then -> IDLE; new start accepted the cycle after.
- REQ-023: Address counter ADDR_BITS wide, saturates at IMAGE_SIZE-1; no wrap to 0 within one frame.
- REQ-024: Output pixel counter width $clog2(IMAGE_SIZE+1); completion decided on count = IMAGE_SIZE, not on address.
- REQ-025: image_bram_rd_addr holds its last value when no read is issued.
- REQ-026: Simultaneous out_full deassert and skid full: pop and new read issue permitted same cycle.

Reset
- REQ-027: reset=1 at any edge -> state IDLE, skid empty, in-flight read discarded, counters 0.
- REQ-028: Reset values: image_bram_rd_addr=0, out_wr_en=0, out_dout=0, busy=0, done=0.
- REQ-029: Reset mid-frame: no out_wr_en the cycle after reset; next start restarts from address 0.
- REQ-030: reset has priority over start in the same cycle.

Verification (WIDTH=4, HEIGHT=2, BRAM word at addr a = 24'h0A0000+a)
- REQ-031: start, out_full=0 -> 8 writes 24'h0A0000..24'h0A0007 on consecutive cycles, first 3 cycles after start edge, done 1 cycle after last write.
- REQ-032: start, out_full toggling 1/0 every cycle -> same 8 words in order, no write while out_full=1.
- REQ-033: out_full=1 for 20 cycles after start -> zero writes, at most 2 reads issued; release -> 8 words in order.
- REQ-034: reset asserted after 3rd write -> outputs at reset values; new start -> full sequence from 24'h0A0000.
- REQ-035: start pulsed again while busy -> ignored, exactly 8 writes and one done pulse.
- REQ-036: Back-to-back frames: start the cycle after done -> second frame of 8 identical words, busy low exactly 1 cycle between.
